// File: rtl/eth_pkt_sched.sv
// Ethernet packet scheduler: splits a byte transfer into UDP packets as the TX
// FIFO fills, with an optional timeout flush of partial packets.
module eth_pkt_sched #(
  parameter int TOTAL_W     = 32,
  parameter int CNT_W       = 12,
  parameter int MAX_PKT     = 1024,
  parameter bit FLUSH_EN    = 1'b1,
  parameter int TIMEOUT_CYC = 125000,
  parameter int GAP_CYC     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               restart_req,
  input  logic [TOTAL_W-1:0] total_data_num,
  input  logic [CNT_W-1:0]   fifo_rd_cnt,
  input  logic               eth_tx_done,
  output logic               pkt_tx_en,
  output logic [15:0]        pkt_length,
  output logic               busy,
  output logic               xfer_done,
  output logic [TOTAL_W-1:0] sent_bytes,
  output logic [15:0]        flush_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [TOTAL_W-1:0] MAX_PKT_T = TOTAL_W'(MAX_PKT);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [15:0]        MAX_LEN   = 16'(MAX_PKT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_SEND,
    S_WAIT_DONE,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, next_state, start_state;

  logic               restart_q;
  logic               restart_edge;
  logic               restart_now;
  logic               restart_hold;
  logic               apply_pend;
  logic               pend;
  logic [TOTAL_W-1:0] pend_total;
  logic [TOTAL_W-1:0] remaining;
  logic [TOTAL_W-1:0] chunk;
  logic [TOTAL_W-1:0] fifo_ext;
  logic               full_ok;
  logic               flush_ok;
  logic [TMR_W-1:0]   timer;
  logic [GAP_W-1:0]   gap_cnt;

  // NOTE: the edge register is deliberately outside reset so it tracks
  // restart_req during reset; a level held high through reset is no edge.
  always_ff @(posedge clk) begin
    restart_q <= restart_req;
  end

  assign restart_edge = restart_req & ~restart_q;
  assign start_state  = (total_data_num != '0) ? S_WAIT_DATA : S_DONE;

  // Edges in SEND/WAIT_DONE are parked until the packet and its gap complete.
  assign restart_now  = restart_edge && (state inside {S_IDLE, S_WAIT_DATA, S_GAP, S_DONE});
  assign restart_hold = restart_edge && (state inside {S_SEND, S_WAIT_DONE});
  assign apply_pend   = (state == S_GAP) && (gap_cnt == GAP_LAST) && pend && !restart_edge;

  assign fifo_ext = TOTAL_W'(fifo_rd_cnt);
  assign chunk    = (remaining < MAX_PKT_T) ? remaining : MAX_PKT_T;
  assign full_ok  = (chunk != '0) && (fifo_ext >= chunk);
  assign flush_ok = FLUSH_EN && (fifo_ext != '0) && (fifo_ext < chunk) && (timer == TMR_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state takes its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (restart_edge) next_state = start_state;
      end
      S_WAIT_DATA: begin
        if (restart_edge)             next_state = start_state;
        else if (full_ok || flush_ok) next_state = S_SEND;
      end
      S_SEND: begin
        next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (eth_tx_done) next_state = S_GAP;
      end
      S_GAP: begin
        if (restart_edge) begin
          next_state = start_state;
        end else if (gap_cnt == GAP_LAST) begin
          if (pend) next_state = (pend_total != '0) ? S_WAIT_DATA : S_DONE;
          else      next_state = (remaining != '0) ? S_WAIT_DATA : S_DONE;
        end
      end
      S_DONE: begin
        next_state = restart_edge ? start_state : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pkt_tx_en = (state == S_SEND);
    busy      = (state != S_IDLE);
    xfer_done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      remaining  <= '0;
      sent_bytes <= '0;
      pend       <= 1'b0;
      pend_total <= '0;
      pkt_length <= '0;
      flush_cnt  <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
    end else begin
      if (restart_now) begin
        remaining  <= total_data_num;
        sent_bytes <= '0;
        pend       <= 1'b0;
      end else if (apply_pend) begin
        remaining  <= pend_total;
        sent_bytes <= '0;
        pend       <= 1'b0;
      end else if (state == S_SEND) begin
        remaining  <= remaining - TOTAL_W'(pkt_length);
        sent_bytes <= sent_bytes + TOTAL_W'(pkt_length);
      end

      if (restart_hold) begin
        pend       <= 1'b1;
        pend_total <= total_data_num;
      end

      // A full chunk wins over a flush when both could apply.
      if ((state == S_WAIT_DATA) && !restart_edge && (full_ok || flush_ok)) begin
        if (full_ok) begin
          pkt_length <= 16'(chunk);
        end else begin
          pkt_length <= 16'(fifo_ext);
          if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
      end

      if ((state == S_WAIT_DATA) && (next_state == S_WAIT_DATA) && !restart_edge &&
          (fifo_rd_cnt != '0)) begin
        if (timer != TMR_LAST) timer <= timer + TMR_W'(1);
      end else begin
        timer <= '0;
      end

      if ((state == S_GAP) && (next_state == S_GAP)) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  a_len_legal: assert property (@(posedge clk) disable iff (!reset_n)
    pkt_tx_en |-> ((pkt_length != 16'd0) && (pkt_length <= MAX_LEN)));

  a_pulses_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(pkt_tx_en && xfer_done));

endmodule

// File: tb/tb_eth_pkt_sched.sv
// Bench for eth_pkt_sched: directed scenarios plus randomized transfers checked
// against a packet-list model built from min(remaining, MAX_PKT) arithmetic.
module tb_eth_pkt_sched;

  localparam int GAP_CYC     = 4;
  localparam int MAX_PKT     = 1024;
  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        restart_req;
  logic        eth_tx_done;
  logic [31:0] total_data_num;
  logic [11:0] fifo_rd_cnt;

  logic        pkt_tx_en, busy, xfer_done;
  logic [15:0] pkt_length, flush_cnt;
  logic [31:0] sent_bytes;

  logic        nf_pkt_tx_en, nf_busy, nf_xfer_done;
  logic [15:0] nf_pkt_length, nf_flush_cnt;
  logic [31:0] nf_sent_bytes;

  int checks     = 0;
  int failures   = 0;
  int tx_seen    = 0;
  int xfer_seen  = 0;
  int nf_tx_seen = 0;

  eth_pkt_sched #(
    .TOTAL_W(32), .CNT_W(12), .MAX_PKT(MAX_PKT), .FLUSH_EN(1'b1),
    .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .restart_req(restart_req),
    .total_data_num(total_data_num), .fifo_rd_cnt(fifo_rd_cnt),
    .eth_tx_done(eth_tx_done), .pkt_tx_en(pkt_tx_en), .pkt_length(pkt_length),
    .busy(busy), .xfer_done(xfer_done), .sent_bytes(sent_bytes), .flush_cnt(flush_cnt)
  );

  eth_pkt_sched #(
    .TOTAL_W(32), .CNT_W(12), .MAX_PKT(MAX_PKT), .FLUSH_EN(1'b0),
    .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut_nf (
    .clk(clk), .reset_n(reset_n), .restart_req(restart_req),
    .total_data_num(total_data_num), .fifo_rd_cnt(fifo_rd_cnt),
    .eth_tx_done(eth_tx_done), .pkt_tx_en(nf_pkt_tx_en), .pkt_length(nf_pkt_length),
    .busy(nf_busy), .xfer_done(nf_xfer_done), .sent_bytes(nf_sent_bytes),
    .flush_cnt(nf_flush_cnt)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_tx_en)    tx_seen++;
    if (xfer_done)    xfer_seen++;
    if (nf_pkt_tx_en) nf_tx_seen++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int total);
    restart_req    = 1'b1;
    total_data_num = total;
    tick();
    restart_req    = 1'b0;
  endtask

  task automatic done_pulse();
    eth_tx_done = 1'b1;
    tick();
    eth_tx_done = 1'b0;
  endtask

  task automatic wait_tx(input bit rnd);
    int n = 0;
    while (!pkt_tx_en && n < 400) begin
      if (rnd) fifo_rd_cnt = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom_range(1024, 4095));
      tick();
      n++;
    end
    check("pkt_tx_en_seen", pkt_tx_en, 1);
  endtask

  task automatic finish_last();
    int lat = 1;
    done_pulse();
    while (!xfer_done && lat < 50) begin
      tick();
      lat++;
    end
    check("xfer_latency", lat, GAP_CYC + 1);
    check("busy_in_done", busy, 1);
    tick();
    check("xfer_one_cycle", xfer_done, 0);
    check("idle_not_busy", busy, 0);
  endtask

  // Expected packet list: repeated min(remaining, MAX_PKT) until nothing is left.
  task automatic run_xfer(input int total, input bit rnd);
    int q[$];
    int cum = 0;
    int npk;
    int xb  = xfer_seen;
    int tb0 = tx_seen;
    for (int r = total; r > 0; r -= MAX_PKT) q.push_back((r < MAX_PKT) ? r : MAX_PKT);
    npk = q.size();
    start(total);
    if (total == 0) begin
      check("zero_xfer_done", xfer_done, 1);
      check("zero_busy", busy, 1);
      tick();
      check("zero_xfer_clear", xfer_done, 0);
      check("zero_busy_clear", busy, 0);
    end else begin
      while (q.size() > 0) begin
        int len;
        len = q.pop_front();
        wait_tx(rnd);
        check("pkt_len", pkt_length, len);
        tick();
        cum += len;
        check("sent_bytes", sent_bytes, cum);
        repeat ($urandom_range(0, 4)) tick();
        if (q.size() == 0) finish_last();
        else done_pulse();
      end
    end
    check("pkt_count", tx_seen - tb0, npk);
    check("one_xfer_done", xfer_seen - xb, 1);
  endtask

  initial begin
    int n, xb, nb, tb0;
    reset_n        = 1'b0;
    restart_req    = 1'b0;
    eth_tx_done    = 1'b0;
    total_data_num = '0;
    fifo_rd_cnt    = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_tx_en", pkt_tx_en, 0);
    check("rst_xfer", xfer_done, 0);
    check("rst_len", pkt_length, 0);
    check("rst_sent", sent_bytes, 0);
    check("rst_flush", flush_cnt, 0);
    reset_n = 1'b1;
    tick();

    // Three packets from 2500 bytes with the FIFO always full, then an empty transfer.
    fifo_rd_cnt = 12'd4095;
    run_xfer(2500, 1'b0);
    run_xfer(0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_xfer(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4000)), 1'b1);
    end

    // Single-cycle latency from data arrival to the packet start.
    fifo_rd_cnt = 12'd0;
    start(600);
    repeat (3) tick();
    check("lat_no_tx", pkt_tx_en, 0);
    fifo_rd_cnt = 12'd600;
    tick();
    check("lat_tx_n1", pkt_tx_en, 1);
    check("lat_len", pkt_length, 600);
    check("lat_sent_n1", sent_bytes, 0);
    tick();
    check("lat_sent_n2", sent_bytes, 600);
    check("lat_tx_n2", pkt_tx_en, 0);
    finish_last();

    // Restart during WAIT_DONE is held until after the gap.
    fifo_rd_cnt = 12'd4095;
    start(2048);
    wait_tx(1'b0);
    check("hold_len0", pkt_length, 1024);
    tick();
    restart_req    = 1'b1;
    total_data_num = 300;
    tick();
    restart_req    = 1'b0;
    total_data_num = 999;
    tick();
    check("hold_len_kept", pkt_length, 1024);
    xb = xfer_seen;
    done_pulse();
    wait_tx(1'b0);
    check("hold_len", pkt_length, 300);
    check("hold_no_xfer", xfer_seen - xb, 0);
    tick();
    check("hold_sent", sent_bytes, 300);
    finish_last();

    // Restart coinciding with eth_tx_done.
    start(2048);
    wait_tx(1'b0);
    tick();
    restart_req    = 1'b1;
    total_data_num = 500;
    eth_tx_done    = 1'b1;
    tick();
    restart_req    = 1'b0;
    eth_tx_done    = 1'b0;
    total_data_num = 7;
    wait_tx(1'b0);
    check("coin_len", pkt_length, 500);
    tick();
    check("coin_sent", sent_bytes, 500);
    finish_last();

    // Restart while waiting for data takes effect immediately.
    fifo_rd_cnt = 12'd0;
    start(3000);
    repeat (3) tick();
    check("wd_busy", busy, 1);
    restart_req    = 1'b1;
    total_data_num = 200;
    tick();
    restart_req    = 1'b0;
    fifo_rd_cnt    = 12'd4095;
    xb = xfer_seen;
    wait_tx(1'b0);
    check("wd_len", pkt_length, 200);
    check("wd_no_xfer", xfer_seen - xb, 0);
    tick();
    check("wd_sent", sent_bytes, 200);
    finish_last();

    // Timeout flush: both instances see the same partially filled FIFO.
    fifo_rd_cnt    = 12'd100;
    total_data_num = 1024;
    restart_req    = 1'b1;
    nb = nf_tx_seen;
    n  = 0;
    while (!pkt_tx_en && n < 40) begin
      tick();
      n++;
      restart_req = 1'b0;
    end
    check("flush_latency", n, TIMEOUT_CYC + 1);
    check("flush_len", pkt_length, 100);
    check("flush_cnt", flush_cnt, 1);
    repeat (20) tick();
    check("nf_no_pkt", nf_tx_seen - nb, 0);
    check("nf_busy", nf_busy, 1);
    check("nf_flush_cnt", nf_flush_cnt, 0);
    done_pulse();
    fifo_rd_cnt = 12'd4095;
    wait_tx(1'b0);
    check("flush_rest_len", pkt_length, 924);
    tick();
    check("flush_rest_sent", sent_bytes, 1024);
    finish_last();
    check("flush_cnt_kept", flush_cnt, 1);

    // Reset in WAIT_DONE with restart_req held high through it.
    start(2048);
    wait_tx(1'b0);
    tick();
    restart_req = 1'b1;
    reset_n     = 1'b0;
    tick();
    reset_n     = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx", pkt_tx_en, 0);
    check("mid_rst_xfer", xfer_done, 0);
    check("mid_rst_len", pkt_length, 0);
    check("mid_rst_sent", sent_bytes, 0);
    check("mid_rst_flush", flush_cnt, 0);
    tb0 = tx_seen;
    xb  = xfer_seen;
    done_pulse();
    repeat (8) tick();
    check("late_done_no_tx", tx_seen - tb0, 0);
    check("late_done_no_xfer", xfer_seen - xb, 0);
    check("held_restart_idle", busy, 0);
    restart_req = 1'b0;
    tick();
    run_xfer(100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_pkt_sched.md
ETH_PKT_SCHED -- requirements
Module: eth_pkt_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter TOTAL_W, 32, width of the total-byte count.
REQ-002 The block SHALL have parameter CNT_W, 12, width of the TX FIFO read-side byte count.
REQ-003 The block SHALL have parameter MAX_PKT, 1024, maximum UDP payload in bytes per packet (legal range 1..1472).
REQ-004 The block SHALL have parameter FLUSH_EN, 1, which enables timeout-based partial-packet flush.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, 125000, the flush timeout in clk cycles (at least 1).
REQ-006 The block SHALL have parameter GAP_CYC, 4, the settle cycles after eth_tx_done before fifo_rd_cnt is re-evaluated (at least 1).

Ports (name, direction, width, meaning):
REQ-007 The block SHALL have port clk, in, 1, the single clock (the 125 MHz Ethernet clock domain).
REQ-008 The block SHALL have port reset_n, in, 1, a synchronous active-low reset.
REQ-009 The block SHALL have port restart_req, in, 1, a level input already synchronised to clk; its rising edge starts a transfer.
REQ-010 The block SHALL have port total_data_num, in, TOTAL_W, the number of bytes to send, sampled on the restart edge.
REQ-011 The block SHALL have port fifo_rd_cnt, in, CNT_W, the number of bytes available in the TX FIFO.
REQ-012 The block SHALL have port eth_tx_done, in, 1, a one-cycle pulse that ends the current packet.
REQ-013 The block SHALL have port pkt_tx_en, out, 1, a one-cycle packet start pulse.
REQ-014 The block SHALL have port pkt_length, out, 16, the payload length of the packet, valid from pkt_tx_en until eth_tx_done.
REQ-015 The block SHALL have port busy, out, 1, high while a transfer is in progress.
REQ-016 The block SHALL have port xfer_done, out, 1, a one-cycle pulse when all bytes have been handed to the MAC.
REQ-017 The block SHALL have port sent_bytes, out, TOTAL_W, the running count of bytes committed in the current transfer.
REQ-018 The block SHALL have port flush_cnt, out, 16, the number of timeout-flushed packets since reset (saturating).

Function
REQ-019 The block SHALL implement states IDLE, WAIT_DATA, SEND, WAIT_DONE, GAP and DONE.
REQ-020 Rising-edge detection on restart_req SHALL use a single registered copy; a restart edge SHALL latch remaining = total_data_num and clear sent_bytes and the timer.
REQ-021 In IDLE, a restart edge SHALL move to WAIT_DATA when remaining > 0, and to DONE when remaining = 0.
REQ-022 The block SHALL compute chunk = min(remaining, MAX_PKT), with the comparison done at TOTAL_W width and fifo_rd_cnt zero-extended.
REQ-023 In WAIT_DATA, when fifo_rd_cnt >= chunk, the block SHALL go to SEND with pkt_length = chunk.
REQ-024 In WAIT_DATA, when FLUSH_EN = 1, fifo_rd_cnt > 0, fifo_rd_cnt < chunk and the timer = TIMEOUT_CYC-1, the block SHALL go to SEND with pkt_length = fifo_rd_cnt and increment flush_cnt, saturating at 0xFFFF.
REQ-025 The flush timer SHALL count only in WAIT_DATA while fifo_rd_cnt is non-zero, and SHALL clear when fifo_rd_cnt = 0 or when WAIT_DATA is left.
REQ-026 SEND SHALL last exactly 1 cycle, assert pkt_tx_en, subtract pkt_length from remaining, add pkt_length to sent_bytes, then go to WAIT_DONE.
REQ-027 Latency from the qualifying WAIT_DATA condition to pkt_tx_en SHALL be 1 cycle, since pkt_tx_en is registered and asserts in the cycle the state is SEND.
REQ-028 In WAIT_DONE, eth_tx_done SHALL move the block to GAP; pkt_length SHALL hold until then.
REQ-029 GAP SHALL last GAP_CYC cycles, then go to WAIT_DATA when remaining > 0, otherwise to DONE.
REQ-030 DONE SHALL last 1 cycle, assert xfer_done, then go to IDLE.
REQ-031 busy SHALL be high in every state except IDLE.
REQ-032 A restart edge in WAIT_DATA or GAP SHALL restart immediately (per REQ-020) and stay in or enter WAIT_DATA, with no xfer_done.
REQ-033 A restart edge in SEND or WAIT_DONE SHALL be held pending; after GAP the pending restart SHALL be applied and any old remainder discarded.
REQ-034 eth_tx_done outside WAIT_DONE SHALL be ignored.
REQ-035 When restart and eth_tx_done coincide in WAIT_DONE, the block SHALL go to GAP with the restart pending.
REQ-036 The block SHALL never produce pkt_length = 0 or pkt_length > MAX_PKT.

Reset
REQ-037 While reset_n = 0 at a clk edge, the state SHALL go to IDLE; pkt_tx_en, xfer_done, busy = 0; pkt_length, sent_bytes, flush_cnt, remaining, the timer and the pending restart = 0; the edge register SHALL load restart_req.
REQ-038 Reset mid-transfer SHALL abandon the transfer with no further pulses; a restart_req held high through reset SHALL NOT start a transfer.

Verification
REQ-039 With MAX_PKT=1024, total=2500 and the FIFO always at 4095, the bench SHALL see pkt_length 1024, 1024, 452, sent_bytes = 2500, and one xfer_done after the third eth_tx_done plus GAP_CYC+1 cycles.
REQ-040 With total=0 and a restart edge, the bench SHALL see no pkt_tx_en, busy high for 1 cycle and xfer_done 1 cycle later.
REQ-041 With FLUSH_EN=1, TIMEOUT_CYC=16, total=1024 and fifo_rd_cnt held at 100, the bench SHALL see pkt_tx_en with length 100 exactly 17 cycles after entry and flush_cnt = 1; with FLUSH_EN=0 it SHALL see no packet.
REQ-042 With fifo_rd_cnt reaching chunk on cycle N, the bench SHALL see pkt_tx_en on N+1 and remaining reduced on N+2.
REQ-043 A restart (total=300) during WAIT_DONE of a 1024-byte packet SHALL give, after eth_tx_done plus GAP, a next packet of length 300 and sent_bytes = 300.
REQ-044 Asserting reset_n = 0 for 1 cycle in WAIT_DONE SHALL return all outputs to zero on the next cycle, and a late eth_tx_done SHALL then have no effect.
